// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and the immediate-format encoding for the immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate extraction: instruction word -> sign-extended immediate and format.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            no_imm
);

    logic signed [31:0] imm32_s;
    fmt_t               fmt_s;

    // Select the immediate layout from the opcode; unknown opcodes yield no immediate.
    always_comb begin
        imm32_s = 32'sd0;
        fmt_s   = FMT_NONE;
        no_imm  = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                imm32_s = {{20{instr[31]}}, instr[31:20]};
                fmt_s   = FMT_I;
            end
            OP_IMM32: begin
                // The W-form ALU ops only exist on RV64.
                if (XLEN == 64) begin
                    imm32_s = {{20{instr[31]}}, instr[31:20]};
                    fmt_s   = FMT_I;
                end else begin
                    no_imm  = 1'b1;
                end
            end
            OP_STORE: begin
                imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt_s   = FMT_S;
            end
            OP_BRANCH: begin
                imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt_s   = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm32_s = {instr[31:12], 12'b0};
                fmt_s   = FMT_U;
            end
            OP_JAL: begin
                imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt_s   = FMT_J;
            end
            default: begin
                no_imm  = 1'b1;
            end
        endcase
    end

    // Signed size cast sign-extends the 32-bit value up to XLEN.
    assign imm = XLEN'(imm32_s);
    assign fmt = fmt_s;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready on both sides and a one-entry skid register.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             no_imm,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_fmt_s;
    logic             dec_no_imm_s;
    logic             accept_s;
    logic             m_free_s;

    logic             in_ready_r;
    logic             m_valid_r;
    logic [XLEN-1:0]  m_imm_r;
    logic [2:0]       m_fmt_r;
    logic             m_no_imm_r;
    logic [TAG_W-1:0] m_tag_r;
    logic             k_valid_r;
    logic [XLEN-1:0]  k_imm_r;
    logic [2:0]       k_fmt_r;
    logic             k_no_imm_r;
    logic [TAG_W-1:0] k_tag_r;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr  (instr),
        .imm    (dec_imm_s),
        .fmt    (dec_fmt_s),
        .no_imm (dec_no_imm_s)
    );

    assign accept_s = in_valid && in_ready_r;
    // M can take a new entry when it is empty or emptying on this edge.
    assign m_free_s = !m_valid_r || out_ready;

    // Main/skid register update; in_ready_r always mirrors an empty skid slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r <= 1'b1;
            m_valid_r  <= 1'b0;
            m_imm_r    <= {XLEN{1'b0}};
            m_fmt_r    <= FMT_NONE;
            m_no_imm_r <= 1'b0;
            m_tag_r    <= {TAG_W{1'b0}};
            k_valid_r  <= 1'b0;
            k_imm_r    <= {XLEN{1'b0}};
            k_fmt_r    <= FMT_NONE;
            k_no_imm_r <= 1'b0;
            k_tag_r    <= {TAG_W{1'b0}};
        end else if (m_free_s) begin
            if (k_valid_r) begin
                m_valid_r  <= 1'b1;
                m_imm_r    <= k_imm_r;
                m_fmt_r    <= k_fmt_r;
                m_no_imm_r <= k_no_imm_r;
                m_tag_r    <= k_tag_r;
            end else if (accept_s) begin
                m_valid_r  <= 1'b1;
                m_imm_r    <= dec_imm_s;
                m_fmt_r    <= dec_fmt_s;
                m_no_imm_r <= dec_no_imm_s;
                m_tag_r    <= in_tag;
            end else begin
                m_valid_r  <= 1'b0;
            end
            k_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else if (accept_s) begin
            k_valid_r  <= 1'b1;
            k_imm_r    <= dec_imm_s;
            k_fmt_r    <= dec_fmt_s;
            k_no_imm_r <= dec_no_imm_s;
            k_tag_r    <= in_tag;
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= !k_valid_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = m_valid_r;
    assign imm       = m_imm_r;
    assign fmt       = m_fmt_r;
    assign no_imm    = m_no_imm_r;
    assign out_tag   = m_tag_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: XLEN=32 and XLEN=64 instances driven in lockstep with directed instruction vectors.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, no_imm32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64, no_imm64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [7:0]  out_tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .fmt(fmt32), .no_imm(no_imm32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .fmt(fmt64), .no_imm(no_imm64), .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm;
        logic [2:0]  f32;
        logic [2:0]  f64;
        logic        n32;
        logic        n64;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        no_imm;
        logic [7:0]  tag;
    } exp_t;

    vec_t vec [10];
    exp_t q32 [$];
    exp_t q64 [$];
    int compared   = 0;
    int mismatched = 0;

    logic        stalled_prev = 1'b0;
    logic [31:0] snap_imm;
    logic [7:0]  snap_tag;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic push(input int i, input logic [7:0] tag);
        exp_t e;
        e.imm = {32'h0000_0000, vec[i].imm[31:0]};
        e.fmt = vec[i].f32; e.no_imm = vec[i].n32; e.tag = tag;
        q32.push_back(e);
        e.imm = vec[i].imm;
        e.fmt = vec[i].f64; e.no_imm = vec[i].n64;
        q64.push_back(e);
    endtask

    // Present one vector, wait (bounded) for in_ready, then return #1 after the accepting edge.
    task automatic send(input int i, input logic [7:0] tag);
        int b = 0;
        instr    = vec[i].ins;
        in_tag   = tag;
        in_valid = 1'b1;
        while (!in_ready32 && b < 50) begin
            @(posedge clk); #1; b++;
        end
        check("send_ready", {63'd0, in_ready32}, 64'd1);
        if (in_ready32) push(i, tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: pop and compare on every output transfer; hold-stability check while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (out_valid32 && out_ready) begin
                if (q32.size() == 0) begin
                    check("unexpected_out32", {56'd0, out_tag32}, 64'hFFFF);
                end else begin
                    e = q32.pop_front();
                    check("imm32", {32'd0, imm32}, e.imm);
                    check("fmt32", {61'd0, fmt32}, {61'd0, e.fmt});
                    check("no_imm32", {63'd0, no_imm32}, {63'd0, e.no_imm});
                    check("tag32", {56'd0, out_tag32}, {56'd0, e.tag});
                end
            end
            if (out_valid64 && out_ready) begin
                if (q64.size() == 0) begin
                    check("unexpected_out64", {56'd0, out_tag64}, 64'hFFFF);
                end else begin
                    e = q64.pop_front();
                    check("imm64", imm64, e.imm);
                    check("fmt64", {61'd0, fmt64}, {61'd0, e.fmt});
                    check("no_imm64", {63'd0, no_imm64}, {63'd0, e.no_imm});
                    check("tag64", {56'd0, out_tag64}, {56'd0, e.tag});
                end
            end
            if (out_valid32 && !out_ready) begin
                if (stalled_prev) begin
                    check("stall_imm", {32'd0, imm32}, {32'd0, snap_imm});
                    check("stall_tag", {56'd0, out_tag32}, {56'd0, snap_tag});
                end
                snap_imm     = imm32;
                snap_tag     = out_tag32;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    initial begin
        vec[0] = '{32'hFFC4A303, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 3'd1, 1'b0, 1'b0}; // lw x6,-4(x9)
        vec[1] = '{32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 3'd3, 1'b0, 1'b0}; // beq -8
        vec[2] = '{32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 3'd4, 1'b0, 1'b0}; // lui
        vec[3] = '{32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, 3'd5, 1'b0, 1'b0}; // jal +2048
        vec[4] = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 3'd4, 1'b0, 1'b0}; // lui x1,0x80000
        vec[5] = '{32'h00000033, 64'h0000_0000_0000_0000, 3'd0, 3'd0, 1'b1, 1'b1}; // add
        vec[6] = '{32'h0000001B, 64'h0000_0000_0000_0000, 3'd0, 3'd1, 1'b1, 1'b0}; // op-imm-32
        vec[7] = '{32'hFE512A23, 64'hFFFF_FFFF_FFFF_FFF4, 3'd2, 3'd2, 1'b0, 1'b0}; // sw x5,-12(x2)
        vec[8] = '{32'h7FF00093, 64'h0000_0000_0000_07FF, 3'd1, 3'd1, 1'b0, 1'b0}; // addi x1,x0,2047
        vec[9] = '{32'hFFFFF117, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 3'd4, 1'b0, 1'b0}; // auipc x2,0xFFFFF

        reset = 1'b1; in_valid = 1'b0; instr = 32'd0; in_tag = 8'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready32}, 64'd1);
        check("rst_imm", imm64, 64'd0);
        check("rst_fmt", {61'd0, fmt32}, 64'd0);
        check("rst_no_imm", {63'd0, no_imm32}, 64'd0);
        check("rst_tag", {56'd0, out_tag32}, 64'd0);

        // Single load, one-cycle latency, then out_valid drops after the transfer.
        send(0, 8'h10);
        check("lat_valid", {63'd0, out_valid32}, 64'd1);
        check("lat_tag", {56'd0, out_tag32}, 64'h10);
        @(posedge clk); #1;
        check("idle_valid", {63'd0, out_valid32}, 64'd0);

        // Back-to-back stream at full rate.
        for (int i = 1; i < 10; i++) begin
            send(i, 8'h20 + 8'(i));
            check("b2b_valid", {63'd0, out_valid32}, 64'd1);
            check("b2b_tag", {56'd0, out_tag64}, {56'd0, 8'h20 + 8'(i)});
        end
        @(posedge clk); #1;

        // Backpressure: 1 -> M, 2 -> K, 3 waits upstream.
        out_ready = 1'b0;
        send(8, 8'd1);
        send(9, 8'd2);
        check("bp_in_ready", {63'd0, in_ready32}, 64'd0);
        check("bp_m_tag", {56'd0, out_tag32}, 64'd1);
        instr = vec[7].ins; in_tag = 8'd3; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp_hold_ready", {63'd0, in_ready64}, 64'd0);
        end
        out_ready = 1'b1;
        push(7, 8'd3);
        @(posedge clk); #1;
        check("bp_rel_valid", {63'd0, out_valid32}, 64'd1);
        check("bp_rel_tag", {56'd0, out_tag32}, 64'd2);
        check("bp_rel_ready", {63'd0, in_ready32}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_third_valid", {63'd0, out_valid32}, 64'd1);
        check("bp_third_tag", {56'd0, out_tag32}, 64'd3);
        @(posedge clk); #1;
        check("bp_drained", {63'd0, out_valid32}, 64'd0);

        // Reset with both M and K occupied discards them.
        out_ready = 1'b0;
        send(0, 8'h61);
        send(1, 8'h62);
        check("pre_rst_ready", {63'd0, in_ready32}, 64'd0);
        reset = 1'b1;
        q32.delete();
        q64.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_valid", {63'd0, out_valid64}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready32}, 64'd1);
        check("mid_rst_imm", imm64, 64'd0);
        check("mid_rst_tag", {56'd0, out_tag32}, 64'd0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        for (int w = 0; w < 50 && (q32.size() != 0 || q64.size() != 0); w++) @(posedge clk);
        check("q32_empty", 64'(q32.size()), 64'd0);
        check("q64_empty", 64'(q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
